// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Register-file write-port arbiter. Merges the in-order pipeline
//            writeback with late (multi-cycle) results held in a 2-entry
//            queue. The pipeline always wins. Queued results that the
//            pipeline overwrites are marked dead, so they drain without
//            writing the register file.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,       // active-low, asynchronous
  input  logic        pipe_wr,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_addr,
  input  logic [31:0] late_data,
  output logic        wr,
  output logic [4:0]  addr3,
  output logic [31:0] data3,
  output logic [1:0]  fifo_count,
  output logic        squash
);

  localparam logic [1:0] C_DEPTH = 2'(DEPTH);

  // Queue storage. Slot 0 is always the head and the queue shifts on a pop.
  logic [4:0]  r_q_addr [2];
  logic [31:0] r_q_data [2];
  logic [1:0]  r_q_live;
  logic [1:0]  r_count;

  logic [4:0]  w_q_addr [2];
  logic [31:0] w_q_data [2];
  logic [1:0]  w_q_live;
  logic [1:0]  w_count;

  logic        w_pipe_live;
  logic        w_accept;
  logic        w_pop;
  logic [1:0]  w_occ;
  logic [1:0]  w_live_k;
  logic        w_kill_q;
  logic        w_late_hit;
  logic        w_late_live;
  logic        w_squash;
  logic        w_tail;

  assign late_ready  = (r_count < C_DEPTH);
  assign fifo_count  = r_count;
  assign w_pipe_live = pipe_wr && (pipe_addr != 5'd0);
  assign w_accept    = late_valid && late_ready;
  assign w_pop       = !w_pipe_live && (r_count != 2'd0);
  assign w_occ       = {r_count == 2'd2, r_count != 2'd0};

  // Kill matching queued entries, then pop/push to form the next queue state.
  always_comb begin
    w_live_k = r_q_live & w_occ;
    w_kill_q = 1'b0;
    if (w_pipe_live && w_live_k[0] && (r_q_addr[0] == pipe_addr)) begin
      w_live_k[0] = 1'b0;
      w_kill_q    = 1'b1;
    end
    if (w_pipe_live && w_live_k[1] && (r_q_addr[1] == pipe_addr)) begin
      w_live_k[1] = 1'b0;
      w_kill_q    = 1'b1;
    end

    // An incoming entry that the pipeline overwrites in the same cycle, or one
    // that targets $0, still takes a slot but never writes.
    w_late_hit  = w_pipe_live && (late_addr == pipe_addr);
    w_late_live = (late_addr != 5'd0) && !w_late_hit;
    w_squash    = w_kill_q || (w_accept && w_late_hit);

    w_q_addr = r_q_addr;
    w_q_data = r_q_data;
    w_q_live = w_live_k;
    if (w_pop) begin
      w_q_addr[0] = r_q_addr[1];
      w_q_data[0] = r_q_data[1];
      w_q_live    = {1'b0, w_live_k[1]};
    end

    // Tail slot after any pop: pop leaves count-1 entries (count is 1 or 2),
    // no pop leaves count entries (count is 0 or 1 when accepting).
    w_tail = w_pop ? r_count[1] : r_count[0];
    if (w_accept) begin
      w_q_addr[w_tail] = late_addr;
      w_q_data[w_tail] = late_data;
      w_q_live[w_tail] = w_late_live;
    end

    w_count = r_count + {1'b0, w_accept} - {1'b0, w_pop};
  end

  // Queue state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_addr[0] <= '0;
      r_q_addr[1] <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_live    <= '0;
      r_count     <= '0;
    end else begin
      r_q_addr <= w_q_addr;
      r_q_data <= w_q_data;
      r_q_live <= w_q_live;
      r_count  <= w_count;
    end
  end

  // Registered write port: pipeline first, else the popped head if still live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr     <= 1'b0;
      addr3  <= '0;
      data3  <= '0;
      squash <= 1'b0;
    end else begin
      squash <= w_squash;
      if (w_pipe_live) begin
        wr    <= 1'b1;
        addr3 <= pipe_addr;
        data3 <= pipe_data;
      end else if (w_pop && w_live_k[0]) begin
        wr    <= 1'b1;
        addr3 <= r_q_addr[0];
        data3 <= r_q_data[0];
      end else begin
        wr <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
